alu_iter_ctrl: RTL and testbench

ALU_ITER_CTRL -- requirements
Module: alu_iter_ctrl

---
 rtl/alu_iter_ctrl.sv | 121 ++++++++++++
 tb/tb_alu_iter_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_iter_ctrl.sv
// Purpose  : iterative driver for an external combinational ALU; runs N Fibonacci-style
//            steps (A<=B, B<=alu_res) and reports the final B value as the result.
// Latency  : done pulses in the cycle after the Nth edge following the start edge
//            (N=0: the cycle after the start edge).
// Backpres.: none; start is only honoured in IDLE and dropped (not queued) in RUN/DONE.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   start, op_in, a_init,   run request and its operands, captured when start is
//   b_init, iter_cnt        sampled high in IDLE
//   alu_a, alu_b, alu_op    operands/opcode to the external ALU (straight from flops)
//   alu_res                 combinational ALU result
//   busy, done, result      RUN indicator, completion pulse, last completed result
module alu_iter_ctrl #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [4:0]        op_in,
  input  logic [DATA_W-1:0] a_init,
  input  logic [DATA_W-1:0] b_init,
  input  logic [CNT_W-1:0]  iter_cnt,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [4:0]        alu_op,
  input  logic [DATA_W-1:0] alu_res,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [4:0]        op_q, op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] result_q, result_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d   = a_init;
          b_d   = b_init;
          op_d  = op_in;
          cnt_d = iter_cnt;
          // A zero-length run never enters RUN, so cnt_q cannot underflow there;
          // the result is simply the untouched second operand.
          if (iter_cnt != '0) begin
            state_d = RUN;
          end else begin
            state_d  = DONE;
            result_d = b_init;
          end
        end
      end

      RUN: begin
        a_d   = b_q;
        b_d   = alu_res;
        cnt_d = cnt_q - 1'b1;
        // The last iteration's ALU output is captured directly as the result
        // (it is also the value B takes on this same edge).
        if (cnt_q == CNT_W'(1)) begin
          result_d = alu_res;
          state_d  = DONE;
        end
      end

      DONE: begin
        // Any start seen here is dropped; a new run needs start in IDLE.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign alu_a  = a_q;
  assign alu_b  = b_q;
  assign alu_op = op_q;
  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_alu_iter_ctrl.sv
// Directed bench for alu_iter_ctrl with a behavioural ALU (op 1 = add, otherwise
// subtract). Inputs change #1 after a rising edge; outputs are checked there too.
module tb_alu_iter_ctrl;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [4:0]        op_in;
  logic [DATA_W-1:0] a_init;
  logic [DATA_W-1:0] b_init;
  logic [CNT_W-1:0]  iter_cnt;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [4:0]        alu_op;
  logic [DATA_W-1:0] alu_res;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] result;

  int n_cmp = 0;
  int n_err = 0;

  alu_iter_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op_in    (op_in),
    .a_init   (a_init),
    .b_init   (b_init),
    .iter_cnt (iter_cnt),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_op   (alu_op),
    .alu_res  (alu_res),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  // External ALU model
  assign alu_res = (alu_op == 5'd1) ? (alu_a + alu_b) : (alu_a - alu_b);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] n);
    start    = 1'b1;
    op_in    = op;
    a_init   = a;
    b_init   = b;
    iter_cnt = n;
  endtask

  initial begin
    rst_n    = 1'b1;
    start    = 1'b0;
    op_in    = '0;
    a_init   = '0;
    b_init   = '0;
    iter_cnt = '0;

    // Reset before any clock edge: async clear
    #1 rst_n = 1'b0;
    #2;
    chk("rst_busy",   {31'd0, busy}, 32'd0);
    chk("rst_done",   {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_alu_a",  alu_a, 32'd0);
    chk("rst_alu_op", {27'd0, alu_op}, 32'd0);
    #9 rst_n = 1'b1;   // t=12, between edges

    // Fibonacci 1,1 for 4 iterations -> B = 2,3,5,8
    load(5'd1, 32'd1, 32'd1, 4'd4);
    step();
    start = 1'b0;
    chk("fib_busy0", {31'd0, busy}, 32'd1);
    chk("fib_a0",    alu_a, 32'd1);
    chk("fib_b0",    alu_b, 32'd1);
    chk("fib_op0",   {27'd0, alu_op}, 32'd1);
    step();
    chk("fib_b1",    alu_b, 32'd2);
    step();
    chk("fib_b2",    alu_b, 32'd3);
    chk("fib_done2", {31'd0, done}, 32'd0);
    step();
    chk("fib_b3",    alu_b, 32'd5);
    chk("fib_busy3", {31'd0, busy}, 32'd1);
    step();
    chk("fib_done",  {31'd0, done}, 32'd1);
    chk("fib_busy4", {31'd0, busy}, 32'd0);
    chk("fib_res",   result, 32'd8);
    step();
    chk("fib_done_1cyc", {31'd0, done}, 32'd0);
    chk("fib_res_hold",  result, 32'd8);

    // N=0: straight to DONE; start held through DONE must be dropped
    load(5'd1, 32'h0000_AAAA, 32'h0000_1234, 4'd0);
    step();
    chk("n0_done",  {31'd0, done}, 32'd1);
    chk("n0_busy",  {31'd0, busy}, 32'd0);
    chk("n0_res",   result, 32'h0000_1234);
    chk("n0_alu_a", alu_a, 32'h0000_AAAA);
    chk("n0_alu_b", alu_b, 32'h0000_1234);
    load(5'd1, 32'd5, 32'd6, 4'd3);   // arrives in DONE
    step();
    start = 1'b0;
    chk("dn_ign_busy", {31'd0, busy}, 32'd0);
    chk("dn_ign_done", {31'd0, done}, 32'd0);
    step();
    chk("dn_ign_busy2", {31'd0, busy}, 32'd0);
    chk("dn_ign_alu_b", alu_b, 32'h0000_1234);

    // Wrap-around passes through unchanged
    load(5'd1, 32'h0000_0000, 32'hFFFF_FFFF, 4'd1);
    step();
    start = 1'b0;
    chk("w1_busy", {31'd0, busy}, 32'd1);
    step();
    chk("w1_done", {31'd0, done}, 32'd1);
    chk("w1_res",  result, 32'hFFFF_FFFF);
    step();
    load(5'd1, 32'hFFFF_FFFF, 32'h0000_0001, 4'd1);
    step();
    start = 1'b0;
    step();
    chk("w2_done", {31'd0, done}, 32'd1);
    chk("w2_res",  result, 32'h0000_0000);
    step();

    // Non-add opcode: 10,3 -> 10-3=7, then 3-7=0xFFFFFFFC
    load(5'd2, 32'd10, 32'd3, 4'd2);
    step();
    start = 1'b0;
    chk("sub_op",  {27'd0, alu_op}, 32'd2);
    step();
    chk("sub_b1",  alu_b, 32'd7);
    step();
    chk("sub_done", {31'd0, done}, 32'd1);
    chk("sub_res",  result, 32'hFFFF_FFFC);
    step();

    // Start during RUN with different inputs is ignored
    load(5'd1, 32'd1, 32'd1, 4'd4);
    step();
    load(5'd2, 32'd7, 32'd9, 4'd2);
    step();
    chk("ovr_a1",  alu_a, 32'd1);
    chk("ovr_b1",  alu_b, 32'd2);
    chk("ovr_op",  {27'd0, alu_op}, 32'd1);
    step();
    step();
    chk("ovr_b3",  alu_b, 32'd5);
    step();
    start = 1'b0;
    chk("ovr_done", {31'd0, done}, 32'd1);
    chk("ovr_res",  result, 32'd8);
    step();
    step();
    chk("ovr_idle_busy", {31'd0, busy}, 32'd0);
    chk("ovr_idle_b",    alu_b, 32'd8);

    // Reset in the 2nd RUN cycle aborts immediately
    load(5'd1, 32'd1, 32'd1, 4'd4);
    step();
    start = 1'b0;
    step();
    chk("ab_busy_pre", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ab_busy",   {31'd0, busy}, 32'd0);
    chk("ab_done",   {31'd0, done}, 32'd0);
    chk("ab_result", result, 32'd0);
    chk("ab_alu_b",  alu_b, 32'd0);
    #2 rst_n = 1'b1;

    // Fresh run after reset: 2,3 for 3 iterations -> 5,8,13
    load(5'd1, 32'd2, 32'd3, 4'd3);
    step();
    start = 1'b0;
    chk("fr_busy", {31'd0, busy}, 32'd1);
    step();
    step();
    chk("fr_b2",   alu_b, 32'd8);
    step();
    chk("fr_done", {31'd0, done}, 32'd1);
    chk("fr_res",  result, 32'd13);
    step();
    chk("fr_idle", {31'd0, done | busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Watchdog
  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
